// File: rtl/register_serializer_pkg.sv
// Shared constants and types for the register_serializer parallel-to-serial link.
package register_serializer_pkg;

    localparam int unsigned WIDTH_DEF = 16;
    localparam int unsigned CNT_W_DEF = $clog2(WIDTH_DEF);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

endpackage

// File: rtl/register_serializer_if.sv
// Parallel-load / serial-out bus between a word producer and the serializer.
interface register_serializer_if #(
    parameter int unsigned WIDTH = register_serializer_pkg::WIDTH_DEF
) ();

    logic [WIDTH-1:0] in;
    logic             load;
    logic             ready;
    logic             sout;
    logic             svalid;
    logic             slast;

    modport master (
        output in,
        output load,
        input  ready,
        input  sout,
        input  svalid,
        input  slast
    );

    modport slave (
        input  in,
        input  load,
        output ready,
        output sout,
        output svalid,
        output slast
    );

endinterface

// File: rtl/register_serializer_bit_counter.sv
// Bit position counter for one serialized word; term_c flags the final bit.
module bit_counter #(
    parameter int unsigned WIDTH = register_serializer_pkg::WIDTH_DEF,
    parameter int unsigned CNT_W = $clog2(WIDTH)
) (
    input  logic clock,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic term_c
);

    logic [CNT_W-1:0] cnt;

    // Clear wins over enable so a back-to-back reload restarts at bit 0.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign term_c = (cnt == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/register_serializer.sv
// Captures a WIDTH-bit word and shifts it out MSB-first with valid/last strobes.
module register_serializer
    import register_serializer_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF
) (
    input  logic                  clock,
    input  logic                  reset,
    register_serializer_if.slave  bus
);

    localparam int unsigned CNT_W    = $clog2(WIDTH);
    localparam logic [0:0]  ST_IDLE  = 1'b0;
    localparam logic [0:0]  ST_SHIFT = 1'b1;

    logic [0:0]       state;
    logic [0:0]       state_d;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] shreg_d;
    logic             term_c;
    logic             shifting_c;
    logic             ready_c;
    logic             accept_c;
    logic             cnt_clr_c;

    assign shifting_c = (state == ST_SHIFT);
    assign ready_c    = ~shifting_c | term_c;
    assign accept_c   = bus.load & ready_c;

    // Counter restarts whenever a word ends or the line is idle.
    assign cnt_clr_c = ~shifting_c | term_c;

    bit_counter #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_bit_counter (
        .clock  (clock),
        .reset  (reset),
        .clr    (cnt_clr_c),
        .en     (shifting_c),
        .term_c (term_c)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
            shreg <= '0;
        end else begin
            state <= state_d;
            shreg <= shreg_d;
        end
    end

    // Next-state: load on accept, shift mid-word, clear shreg when falling idle.
    always_comb begin
        state_d = state;
        shreg_d = shreg;
        case (state)
            ST_IDLE: begin
                if (accept_c) begin
                    shreg_d = bus.in;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (!term_c) begin
                    shreg_d = {shreg[WIDTH-2:0], 1'b0};
                end else if (bus.load) begin
                    shreg_d = bus.in;
                end else begin
                    shreg_d = '0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                shreg_d = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // shreg is held at zero while idle, so its MSB is already 0 there.
    assign bus.ready  = ready_c;
    assign bus.svalid = shifting_c;
    assign bus.sout   = shreg[WIDTH-1];
    assign bus.slast  = shifting_c & term_c;

endmodule

// File: tb/tb_register_serializer.sv
// Randomized and directed bench for register_serializer against a bit-queue model.
module tb_register_serializer;

    localparam int unsigned W = 16;

    logic clock = 1'b0;
    logic reset = 1'b1;

    register_serializer_if #(.WIDTH(W)) bus ();

    register_serializer #(.WIDTH(W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Each entry is {data_bit, last_flag}; head is the bit on the line this cycle.
    logic [1:0] q[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic model_ready();
        return (q.size() <= 1);
    endfunction

    task automatic check_outputs(input string tag);
        logic [1:0] head;
        head = (q.size() > 0) ? q[0] : 2'b00;
        check_eq({tag, ".svalid"}, 32'(bus.svalid), 32'(q.size() > 0));
        check_eq({tag, ".sout"},   32'(bus.sout),   32'(head[1]));
        check_eq({tag, ".slast"},  32'(bus.slast),  32'(head[0]));
        check_eq({tag, ".ready"},  32'(bus.ready),  32'(model_ready()));
    endtask

    // Drive one cycle of inputs at the falling edge, advance the model at the rising edge.
    task automatic step(input string tag, input logic ld, input logic [W-1:0] d);
        logic accept;
        bus.load = ld;
        bus.in   = d;
        accept   = ld && model_ready();
        @(posedge clock);
        if (q.size() > 0) void'(q.pop_front());
        if (accept) begin
            for (int i = W - 1; i >= 0; i--) q.push_back({d[i], (i == 0)});
        end
        @(negedge clock);
        check_outputs(tag);
    endtask

    task automatic idle(input string tag, input int n);
        for (int i = 0; i < n; i++) step(tag, 1'b0, W'($urandom));
    endtask

    initial begin
        bus.load = 1'b0;
        bus.in   = '0;
        @(negedge clock);
        @(negedge clock);
        check_outputs("reset_hold");
        reset = 1'b0;
        idle("post_reset", 2);

        // Single word followed by a long idle hold
        step("single", 1'b1, 16'hA5C3);
        idle("single_tail", 15);
        idle("idle_hold", 20);

        // Back-to-back: load held through the first word's last bit
        step("b2b", 1'b1, 16'h8001);
        for (int i = 0; i < 16; i++) step("b2b", 1'b1, 16'h7FFE);
        idle("b2b_tail", 18);

        // Load pulse mid-word must be ignored
        step("ignore", 1'b1, 16'h0000);
        idle("ignore", 6);
        step("ignore_pulse", 1'b1, 16'h1234);
        idle("ignore_tail", 12);

        // Input changes during a word have no effect
        step("isolate", 1'b1, 16'hF00F);
        for (int i = 0; i < 17; i++) step("isolate", 1'b0, W'($urandom));

        // Asynchronous reset in the middle of a word
        step("rst_word", 1'b1, 16'hFFFF);
        idle("rst_word", 4);
        #2;
        reset = 1'b1;
        #1;
        q.delete();
        check_outputs("rst_async");
        @(negedge clock);
        reset = 1'b0;
        check_outputs("rst_release");
        step("rst_next", 1'b1, 16'h0001);
        idle("rst_next", 20);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            step("rand", 1'($urandom_range(0, 3) != 0), W'($urandom));
        end
        idle("rand_drain", 20);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/register_serializer.md
# register_serializer

Parallel-in, serial-out converter for 16-bit data words: the transmit end of a serial link whose receive end is a shift-in Register. It captures a word in one cycle, then drives it MSB-first on a 1-bit serial line over WIDTH consecutive cycles. A valid/last strobe pair marks the bit stream, and a ready/load handshake allows back-to-back words with no idle gap. It sits between any Register/ALU result path and a 1-bit serial channel.

## Interface
- WIDTH, default 16: word width in bits; must be ≥ 2.
- clock  input  1  rising-edge system clock; the only clock.
- reset  input  1  asynchronous, active-high; forces idle state immediately.
- in  input  WIDTH  parallel word; sampled only on an accepted load.
- load  input  1  request to transmit `in`; accepted when load & ready at a rising edge.
- ready  output  1  block can accept a word this cycle.
- sout  output  1  current serial bit, MSB first; 0 when not valid.
- svalid  output  1  sout carries a data bit this cycle.
- slast  output  1  high with the final bit (bit 0) of a word.

## Operation
- State: IDLE, SHIFT; shift register shreg[WIDTH-1:0]; bit counter cnt, clog2(WIDTH) bits.
- IDLE: ready=1, svalid=0, sout=0, slast=0. On load & ready: shreg<=in, cnt<=0, go to SHIFT.
- SHIFT: svalid=1, sout=shreg[WIDTH-1], slast=(cnt==WIDTH-1), ready=slast.
- On each edge in SHIFT with cnt<WIDTH-1: shreg<=shreg<<1 (zero fill), cnt<=cnt+1.
- On an edge with slast=1 and load=1: shreg<=in, cnt<=0, stay in SHIFT (back-to-back).
- On an edge with slast=1 and load=0: go to IDLE; shreg and cnt are don't-care, clear to 0.
- load while ready=0 is ignored; `in` changes during SHIFT have no effect.
- cnt never exceeds WIDTH-1; there is no wrap beyond the final bit.

## Timing
- Reset (asynchronous assert, synchronous release at the next edge): state=IDLE, shreg=0, cnt=0; ready=1, svalid=0, sout=0, slast=0.
- Reset during SHIFT aborts the word; no partial-word completion and no slast.
- Latency: load accepted at edge E; bit WIDTH-1 appears in the cycle after E; bit 0 (slast) appears in the cycle after edge E+WIDTH-1.
- Word occupies exactly WIDTH cycles of svalid=1.
- Continuous load gives 100% line utilisation: svalid stays high and slast pulses every WIDTH cycles.
- All outputs are decoded from registered state only; there are no combinational paths from in or load to any output.

## Structure
- Shared package: WIDTH default constant, CNT_W = clog2(WIDTH), state enum {IDLE, SHIFT}.
- One sub-module, `bit_counter`: a CNT_W-bit counter with clear and enable, and terminal output at WIDTH-1. It drives slast and the SHIFT exit.
- shreg is a WIDTH-bit load/shift register; the FSM is inline in the top module.

## Test plan
- Reset check: assert reset mid-word (after 5 bits of 16'hFFFF) -> ready=1, svalid=0, sout=0, slast=0 immediately; next load of 16'h0001 sends 15 zeros then a 1 with slast.
- Single word: load 16'hA5C3 from IDLE -> 16 cycles of svalid, sout = 1010 0101 1100 0011; slast only on the 16th; then IDLE with ready=1.
- Back-to-back: hold load=1 with 16'h8001 then 16'h7FFE -> 32 contiguous valid cycles, slast on cycles 16 and 32, and no gap.
- Ignored load: pulse load with 16'h1234 during bit 7 of 16'h0000 -> the stream stays all zeros and 16'h1234 is never transmitted.
- Input isolation: change `in` every cycle during SHIFT of 16'hF00F -> the transmitted bits remain 1111 0000 0000 1111.
- Idle hold: load=0 for 20 cycles after a word -> svalid=0, sout=0, ready=1 throughout.
